// File: rtl/tdm_pkg.sv
// Shared constants for the 1-to-16 TDM demultiplexer.
// Lane count, slot index width and last-slot index.
package tdm_pkg;

  localparam int N_LANES_D = 16;
  localparam int SEL_W_D   = $clog2(N_LANES_D);
  localparam int LAST_SLOT = N_LANES_D - 1;

  function automatic int last_slot(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/tdm_demux_1to16_if.sv
// Serial-in / frame-out bundle of the TDM demultiplexer.
// master drives the stream and consumes frames; slave is the demux.
interface tdm_demux_1to16_if
  import tdm_pkg::*;
#(
  parameter int N_LANES = N_LANES_D,
  parameter int SEL_W   = $clog2(N_LANES)
);

  logic               din;
  logic               din_valid;
  logic               sync;
  logic               out_ready;
  logic               ovf_clr;
  logic [N_LANES-1:0] data_out;
  logic               out_valid;
  logic [N_LANES-1:0] lane_q;
  logic [SEL_W-1:0]   slot_q;
  logic               overflow;

  modport master (
    output din, din_valid, sync, out_ready, ovf_clr,
    input  data_out, out_valid, lane_q, slot_q, overflow
  );

  modport slave (
    input  din, din_valid, sync, out_ready, ovf_clr,
    output data_out, out_valid, lane_q, slot_q, overflow
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot pointer for the TDM demux: sync restarts it,
// each valid bit advances it, wrapping after the last slot.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_LANES = N_LANES_D,
  parameter int SEL_W   = $clog2(N_LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] slot_q,
  output logic             is_last
);

  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(last_slot(N_LANES));

  logic [SEL_W-1:0] slot_d;

  // Sync with data puts this bit in slot 0, so the next one goes to 1.
  always_comb begin
    slot_d = slot_q;
    if (sync) begin
      slot_d = din_valid ? SEL_W'(1) : '0;
    end else if (din_valid) begin
      slot_d = slot_q + SEL_W'(1);
    end
  end

  // Slot pointer register; power-of-two lane count wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign is_last = (slot_q == LAST);

endmodule

// File: rtl/tdm_demux_1to16.sv
// Sequential 1-to-16 demultiplexer: assembles serial bits into
// frames, offers them on valid/ready, and mirrors din per lane.
module tdm_demux_1to16
  import tdm_pkg::*;
#(
  parameter int N_LANES = N_LANES_D,
  parameter int SEL_W   = $clog2(N_LANES)
) (
  input logic              clk,
  input logic              rst_n,
  tdm_demux_1to16_if.slave bus
);

  logic [SEL_W-1:0]   slot_q;
  logic               is_last;
  logic [N_LANES-1:0] asm_q;
  logic [N_LANES-1:0] asm_d;
  logic [N_LANES-1:0] frame;
  logic [N_LANES-1:0] lane_d;
  logic [SEL_W-1:0]   lane_idx;
  logic [N_LANES-1:0] data_q;
  logic               valid_q;
  logic               ovf_q;
  logic [N_LANES-1:0] lane_q;
  logic               complete;
  logic               load;
  logic               xfer;

  tdm_slot_counter #(
    .N_LANES (N_LANES),
    .SEL_W   (SEL_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_valid (bus.din_valid),
    .sync      (bus.sync),
    .slot_q    (slot_q),
    .is_last   (is_last)
  );

  assign complete = bus.din_valid && !bus.sync && is_last;
  assign xfer     = valid_q && bus.out_ready;
  assign load     = complete && (!valid_q || bus.out_ready);

  // Next assembly state and the frame including this cycle's bit.
  always_comb begin
    frame         = asm_q;
    frame[slot_q] = bus.din;
    asm_d         = asm_q;
    if (bus.sync) begin
      asm_d = '0;
      if (bus.din_valid) asm_d[0] = bus.din;
    end else if (bus.din_valid) begin
      asm_d = frame;
    end
  end

  // One-hot view of the incoming bit at the slot it targets.
  always_comb begin
    lane_d   = '0;
    lane_idx = bus.sync ? '0 : slot_q;
    if (bus.din_valid) lane_d[lane_idx] = bus.din;
  end

  // Assembly register and per-lane view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q  <= '0;
      lane_q <= '0;
    end else begin
      asm_q  <= asm_d;
      lane_q <= lane_d;
    end
  end

  // Output buffer: a completion reloads it when free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= frame;
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_q <= 1'b0;
    else if (complete && !load)  ovf_q <= 1'b1;
    else if (bus.ovf_clr)        ovf_q <= 1'b0;
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.lane_q    = lane_q;
  assign bus.slot_q    = slot_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_tdm_demux_1to16.sv
// Scoreboard bench for tdm_demux_1to16: frames go into a queue,
// a negedge monitor checks each handshake transfer.
module tb_tdm_demux_1to16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] exp_q[$];

  tdm_demux_1to16_if bus();

  tdm_demux_1to16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got %h expected none",
                 bus.data_out);
      end else begin
        chk("frame", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.ovf_clr   = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic s);
    bus.din       = b;
    bus.din_valid = 1'b1;
    bus.sync      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v,
                           input int lo, input int hi,
                           input logic s);
    for (int i = lo; i <= hi; i++)
      send_bit(v[i], s && (i == lo));
  endtask

  task automatic step();
    idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b1;
    #12;
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_slot", 32'(bus.slot_q), 0);
    chk("rst_lane", 32'(bus.lane_q), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic frame
    exp_q.push_back(16'hB5C3);
    send_bits(16'hB5C3, 0, 15, 1'b1);
    chk("t1_valid_hi", 32'(bus.out_valid), 1);
    chk("t1_data", 32'(bus.data_out), 32'h0000B5C3);
    chk("t1_slot", 32'(bus.slot_q), 0);
    step();
    chk("t1_valid_lo", 32'(bus.out_valid), 0);
    chk("t1_ovf", 32'(bus.overflow), 0);

    // 2: overflow
    bus.out_ready = 1'b0;
    exp_q.push_back(16'hB5C3);
    send_bits(16'hB5C3, 0, 15, 1'b1);
    send_bits(16'h1234, 0, 15, 1'b1);
    idle();
    chk("t2_data", 32'(bus.data_out), 32'h0000B5C3);
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_ovf", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(bus.overflow), 0);
    bus.out_ready = 1'b1;
    step();
    chk("t2_drained", 32'(bus.out_valid), 0);

    // 3: sync mid-frame
    exp_q.push_back(16'hA5A5);
    send_bits(16'hFFFF, 0, 4, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("t3_sync_slot", 32'(bus.slot_q), 1);
    send_bits(16'hA5A5, 1, 14, 1'b0);
    chk("t3_not_yet", 32'(bus.out_valid), 0);
    send_bits(16'hA5A5, 15, 15, 1'b0);
    chk("t3_valid", 32'(bus.out_valid), 1);
    chk("t3_data", 32'(bus.data_out), 32'h0000A5A5);
    chk("t3_ovf", 32'(bus.overflow), 0);
    step();

    // 4: reset mid-frame
    send_bits(16'hFFFF, 0, 6, 1'b0);
    chk("t4_lane_pre", 32'(bus.lane_q), 32'h40);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_data", 32'(bus.data_out), 0);
    chk("t4_valid", 32'(bus.out_valid), 0);
    chk("t4_lane", 32'(bus.lane_q), 0);
    chk("t4_slot", 32'(bus.slot_q), 0);
    chk("t4_ovf", 32'(bus.overflow), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 0, 15, 1'b0);
    chk("t4_data_post", 32'(bus.data_out), 32'h00001234);
    step();

    // 5: lane_q
    send_bits(16'h0000, 0, 8, 1'b0);
    chk("t5_slot9", 32'(bus.slot_q), 9);
    send_bit(1'b1, 1'b0);
    chk("t5_lane9", 32'(bus.lane_q), 32'h0200);
    step();
    chk("t5_lane_idle", 32'(bus.lane_q), 0);
    send_bit(1'b0, 1'b0);
    chk("t5_lane_zero", 32'(bus.lane_q), 0);
    idle();
    bus.sync = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_sync_idle", 32'(bus.slot_q), 0);
    idle();

    // 6: handshake collision
    bus.out_ready = 1'b0;
    exp_q.push_back(16'hB5C3);
    exp_q.push_back(16'h00FF);
    send_bits(16'hB5C3, 0, 15, 1'b0);
    send_bits(16'h00FF, 0, 14, 1'b0);
    chk("t6_hold", 32'(bus.data_out), 32'h0000B5C3);
    bus.out_ready = 1'b1;
    send_bits(16'h00FF, 15, 15, 1'b0);
    chk("t6_valid", 32'(bus.out_valid), 1);
    chk("t6_data", 32'(bus.data_out), 32'h000000FF);
    chk("t6_ovf", 32'(bus.overflow), 0);
    step();
    chk("t6_drained", 32'(bus.out_valid), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to16.md
Name: tdm_demux_1to16

Overview:
- Sequential 1-to-16 demultiplexer; the receive-side counterpart of the team's 16:1 bit-select mux.
- Takes a serial bit stream, one bit per valid cycle, and distributes the bits to 16 slots by an internal slot counter.
- Delivers each assembled 16-bit frame on a valid/ready output. Also drives a registered one-hot per-lane view of the current bit.
- Sits between a serialiser/link and parallel consumers.

Parameters:
- N_LANES, 16: number of output slots/lanes (power of two, at least 2).
- SEL_W, 4: slot index width, equal to clog2(N_LANES).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- sync  input  1  frame-start marker; forces the current bit into slot 0.
- out_ready  input  1  consumer accepts data_out.
- ovf_clr  input  1  clears the sticky overflow flag.
- data_out  output  N_LANES  last assembled frame; slot i maps to bit i.
- out_valid  output  1  data_out holds an unconsumed frame.
- lane_q  output  N_LANES  registered one-hot demux of din.
- slot_q  output  SEL_W  slot the next valid bit will be written to.
- overflow  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (asynchronous, rst_n low): the following are forced to 0 immediately and held while rst_n is low: slot counter, assembly register, data_out, out_valid, lane_q, overflow.
- Reset mid-frame discards the partial frame. The first valid bit after release goes to slot 0.
- Slot write, when din_valid=1 and sync=0: asm[slot_q] <= din, slot_q <= slot_q+1. Wraps from N_LANES-1 to 0.
- Sync with din_valid=1:
  - Assembly register cleared, then asm[0] <= din.
  - slot_q <= 1.
  - Partial frame discarded; no completion and no overflow are generated.
- Sync with din_valid=0: asm cleared, slot_q <= 0.
- Idle (din_valid=0, sync=0): no change to slot_q or asm.
- Frame completion occurs on a valid, non-sync write with slot_q==N_LANES-1.
  - The full frame, including the bit written that cycle, is the candidate for data_out.
  - Latency: data_out and out_valid update at the same edge that writes the last bit. They are visible the cycle after the 16th valid bit is presented.
- Output handshake:
  - Transfer occurs when out_valid=1 and out_ready=1.
  - After a transfer, out_valid drops at the next edge unless a completion occurs in the same cycle. In that case data_out loads the new frame and out_valid stays 1.
  - data_out holds its value after transfer until the next load. It is not cleared.
- Overflow:
  - Trigger: a completion while out_valid=1 and out_ready=0.
  - Effect: the new frame is dropped, data_out and out_valid are unchanged, and overflow <= 1.
  - overflow is sticky until ovf_clr=1. If set and clear occur in the same cycle, set wins.
- lane_q:
  - Each edge, lane_q <= 0, except that when din_valid=1, bit lane_q[slot] <= din.
  - The slot index is 0 if sync=1, otherwise slot_q.
  - Result: one-cycle-latency registered demux; all other bits are 0.
- Assembly is unaffected by out_ready. Input is never back-pressured; only completed frames can be lost.

Decomposition:
- Shared package tdm_pkg: N_LANES default, SEL_W, and a last-slot constant (N_LANES-1).
- One sub-module, tdm_slot_counter:
  - Holds slot_q with sync/advance/wrap.
  - Outputs the is_last flag.
  - Top level holds the assembly register, output buffer, overflow flag and lane_q.

Test Plan:
1. Basic frame: pulse sync with the first bit, then stream 16'hB5C3 LSB first on 16 consecutive valid cycles, out_ready=1. Required: data_out=16'hB5C3, out_valid high exactly one cycle, overflow=0, slot_q=0 afterwards.
2. Overflow: out_ready=0; send frames 16'hB5C3 then 16'h1234. Required: data_out stays 16'hB5C3, out_valid=1, overflow=1. Then ovf_clr=1 for one cycle gives overflow=0.
3. Sync mid-frame: send 5 bits of 16'hFFFF, then sync with din=1, then 15 bits forming 16'hA5A5. Required: data_out=16'hA5A5, no overflow, out_valid after the 15th post-sync bit.
4. Reset mid-frame: 7 valid bits, then rst_n low between clock edges. Required: every output 0 immediately. After release, 16'h1234 assembles correctly from slot 0.
5. lane_q: drive slot_q to 9, then din_valid=1 with din=1 for one cycle, followed by idle. Required: lane_q=16'h0200 for one cycle, then 16'h0000. With din=0, lane_q stays 16'h0000.
6. Handshake collision: out_valid=1 holding 16'hB5C3. out_ready rises in the same cycle the last bit of 16'h00FF completes. Required: out_valid stays 1, data_out=16'h00FF, overflow=0.
